// File: rtl/output_wrapper_pkg.sv
// Shared types and sizing helpers for the divider result stream serializer.
package output_wrapper_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Bus beats needed to send one Quotient/Remainder pair.
  function automatic int unsigned beats(input int unsigned data_w, input int unsigned bus_w);
    return (2 * data_w) / bus_w;
  endfunction

  function automatic int unsigned pair_width(input int unsigned data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head entry is visible on rdata without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
    else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/result_stream_serializer.sv
// Buffers divider result pairs and streams them out as BUS_W-bit beats over a
// ReceiveData/OutBuffFull handshake.
module result_stream_serializer
  import output_wrapper_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Ready,
  input  logic [DATA_W-1:0] Quotient,
  input  logic [DATA_W-1:0] Remainder,
  input  logic              ReceiveData,
  output logic              ReadyForInput,
  output logic              OutBuffFull,
  output logic [BUS_W-1:0]  DataOut,
  output logic              Overflow,
  output logic [LVL_W-1:0]  Level
);

  localparam int unsigned PAIR_W = pair_width(DATA_W);
  localparam int unsigned BEATS  = beats(DATA_W, BUS_W);
  localparam int unsigned CHUNKS = DATA_W / BUS_W;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  logic [PAIR_W-1:0] fifo_rdata, ordered;
  logic              fifo_full, fifo_empty, fifo_pop, push;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [PAIR_W-1:0] shreg_q, shreg_d;
  logic [BUS_W-1:0]  data_out_q, data_out_d;
  logic              overflow_q, overflow_d;
  logic              last_beat;

  assign ReadyForInput = !fifo_full;
  assign push          = Ready && !fifo_full;
  assign OutBuffFull   = (state_q == SEND);
  assign DataOut       = data_out_q;
  assign Overflow      = overflow_q;
  assign last_beat     = (beat_q == BEAT_W'(BEATS - 1));

  sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata ({Quotient, Remainder}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Level)
  );

  // Rearrange chunks at load time so the shifter always emits its top chunk next.
  always_comb begin
    ordered = '0;
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < int'(CHUNKS); c++) begin
        ordered[(w * CHUNKS + c) * BUS_W +: BUS_W] =
          fifo_rdata[(w * CHUNKS + ((MSB_FIRST != 0) ? c : (CHUNKS - 1 - c))) * BUS_W +: BUS_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q | (Ready && fifo_full);
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_d    = SEND;
          beat_d     = '0;
          data_out_d = ordered[PAIR_W-1 -: BUS_W];
          shreg_d    = ordered << BUS_W;
        end
      end
      SEND: begin
        if (ReceiveData) begin
          if (last_beat) begin
            if (!fifo_empty) begin
              // Back-to-back reload keeps the bus busy with no idle cycle.
              fifo_pop   = 1'b1;
              beat_d     = '0;
              data_out_d = ordered[PAIR_W-1 -: BUS_W];
              shreg_d    = ordered << BUS_W;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            data_out_d = shreg_q[PAIR_W-1 -: BUS_W];
            shreg_d    = shreg_q << BUS_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_result_stream_serializer.sv
// Scoreboard bench for result_stream_serializer: default, LSB-first and 32-bit instances.
module tb_result_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        rdy_a, rd_a, rfi_a, obf_a, ovf_a;
  logic [15:0] q_a, r_a;
  logic [7:0]  do_a;
  logic [2:0]  lvl_a;

  logic        rdy_b, rd_b, rfi_b, obf_b, ovf_b;
  logic [15:0] q_b, r_b;
  logic [7:0]  do_b;
  logic [2:0]  lvl_b;

  logic        rdy_c, rd_c, rfi_c, obf_c, ovf_c;
  logic [31:0] q_c, r_c;
  logic [7:0]  do_c;
  logic [2:0]  lvl_c;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  result_stream_serializer u_dut_a (
    .clk(clk), .reset(rst_n), .Ready(rdy_a), .Quotient(q_a), .Remainder(r_a),
    .ReceiveData(rd_a), .ReadyForInput(rfi_a), .OutBuffFull(obf_a), .DataOut(do_a),
    .Overflow(ovf_a), .Level(lvl_a)
  );

  result_stream_serializer #(.MSB_FIRST(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .Ready(rdy_b), .Quotient(q_b), .Remainder(r_b),
    .ReceiveData(rd_b), .ReadyForInput(rfi_b), .OutBuffFull(obf_b), .DataOut(do_b),
    .Overflow(ovf_b), .Level(lvl_b)
  );

  result_stream_serializer #(.DATA_W(32), .BUS_W(8)) u_dut_c (
    .clk(clk), .reset(rst_n), .Ready(rdy_c), .Quotient(q_c), .Remainder(r_c),
    .ReceiveData(rd_c), .ReadyForInput(rfi_c), .OutBuffFull(obf_c), .DataOut(do_c),
    .Overflow(ovf_c), .Level(lvl_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats for a 16-bit pair on instance A (MSB first) or B (LSB first).
  task automatic exp16(input bit to_b, input logic [15:0] q, input logic [15:0] r);
    if (!to_b) begin
      exp_a.push_back(q[15:8]); exp_a.push_back(q[7:0]);
      exp_a.push_back(r[15:8]); exp_a.push_back(r[7:0]);
    end else begin
      exp_b.push_back(q[7:0]); exp_b.push_back(q[15:8]);
      exp_b.push_back(r[7:0]); exp_b.push_back(r[15:8]);
    end
  endtask

  task automatic drain(input int which, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      case (which)
        0:       done = (exp_a.size() == 0) && !obf_a;
        1:       done = (exp_b.size() == 0) && !obf_b;
        default: done = (exp_c.size() == 0) && !obf_c;
      endcase
      if (!done) step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: instance %0d still busy after %0d cycles, expected idle",
               which, max_cycles);
    end
  endtask

  // Monitor: every accepted beat must match the head of its instance's queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (obf_a && rd_a) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_a: got unexpected beat %h, expected none", do_a);
        end else begin
          e = exp_a.pop_front();
          check("beat_a", 32'(do_a), 32'(e));
        end
      end
      if (obf_b && rd_b) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_b: got unexpected beat %h, expected none", do_b);
        end else begin
          e = exp_b.pop_front();
          check("beat_b", 32'(do_b), 32'(e));
        end
      end
      if (obf_c && rd_c) begin
        if (exp_c.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_c: got unexpected beat %h, expected none", do_c);
        end else begin
          e = exp_c.pop_front();
          check("beat_c", 32'(do_c), 32'(e));
        end
      end
    end
  end

  initial begin
    int exp_lvl[6] = '{1, 1, 2, 3, 4, 4};
    int exp_rfi[6] = '{1, 1, 1, 1, 0, 0};
    logic [7:0] c32[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};

    rst_n = 1'b0;
    {rdy_a, rd_a, rdy_b, rd_b, rdy_c, rd_c} = '0;
    q_a = '0; r_a = '0; q_b = '0; r_b = '0; q_c = '0; r_c = '0;
    step(); step();
    check("rst_obf", 32'(obf_a), 32'd0);
    check("rst_dataout", 32'(do_a), 32'd0);
    check("rst_level", 32'(lvl_a), 32'd0);
    check("rst_rfi", 32'(rfi_a), 32'd1);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: MSB-first, latency
    rd_a = 1'b1; q_a = 16'h1234; r_a = 16'hABCD; exp16(1'b0, q_a, r_a);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    check("t1_obf_edge_n", 32'(obf_a), 32'd0);
    step();
    check("t1_obf_edge_n1", 32'(obf_a), 32'd1);
    check("t1_first_beat", 32'(do_a), 32'h12);
    drain(0, 12);
    check("t1_level_end", 32'(lvl_a), 32'd0);

    // 2: LSB-first
    rd_b = 1'b1; q_b = 16'h1234; r_b = 16'hABCD; exp16(1'b1, q_b, r_b);
    rdy_b = 1'b1;
    step();
    rdy_b = 1'b0;
    drain(1, 12);

    // 6: 32-bit words
    rd_c = 1'b1; q_c = 32'hDEADBEEF; r_c = 32'h01234567;
    for (int i = 0; i < 8; i++) exp_c.push_back(c32[i]);
    rdy_c = 1'b1;
    step();
    rdy_c = 1'b0;
    drain(2, 16);

    // 4: stall mid-result
    rd_a = 1'b1; q_a = 16'h1234; r_a = 16'hABCD; exp16(1'b0, q_a, r_a);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    step(); step(); step();
    rd_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_data", 32'(do_a), 32'hAB);
      check("t4_hold_obf", 32'(obf_a), 32'd1);
    end
    rd_a = 1'b1;
    drain(0, 10);

    // 3: fill, overflow, then gap-free drain
    rd_a = 1'b0;
    check("t3_ovf_before", 32'(ovf_a), 32'd0);
    for (int i = 0; i < 6; i++) begin
      q_a = {8'(8'h10 + i), 8'(8'h20 + i)};
      r_a = {8'(8'h30 + i), 8'(8'h40 + i)};
      if (i < 5) exp16(1'b0, q_a, r_a);
      rdy_a = 1'b1;
      step();
      check("t3_level", 32'(lvl_a), 32'(exp_lvl[i]));
      check("t3_rfi", 32'(rfi_a), 32'(exp_rfi[i]));
    end
    rdy_a = 1'b0;
    check("t3_ovf_set", 32'(ovf_a), 32'd1);
    rd_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("t3_no_bubble", 32'(obf_a), 32'd1);
      step();
    end
    check("t3_obf_after", 32'(obf_a), 32'd0);
    check("t3_all_beats", 32'(exp_a.size()), 32'd0);
    check("t3_ovf_sticky", 32'(ovf_a), 32'd1);

    // 5: reset mid-result with entries queued
    rd_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q_a = {8'(8'h55 + i), 8'(8'h66 + i)};
      r_a = 16'h7788;
      rdy_a = 1'b1;
      step();
    end
    rdy_a = 1'b0;
    step();
    check("t5_level_queued", 32'(lvl_a), 32'd2);
    exp_a.push_back(8'h55); exp_a.push_back(8'h66);
    rd_a = 1'b1;
    step(); step();
    rd_a = 1'b0;
    check("t5_mid_data", 32'(do_a), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_obf", 32'(obf_a), 32'd0);
    check("t5_rst_data", 32'(do_a), 32'd0);
    check("t5_rst_level", 32'(lvl_a), 32'd0);
    check("t5_rst_rfi", 32'(rfi_a), 32'd1);
    check("t5_rst_ovf", 32'(ovf_a), 32'd0);
    step();
    rst_n = 1'b1;
    rd_a = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t5_no_stale_obf", 32'(obf_a), 32'd0);
    check("t5_level_after", 32'(lvl_a), 32'd0);
    check("t5_queue_empty", 32'(exp_a.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
